// File: rtl/prince_ti_pkg.sv
// Shared types and constants for the PRINCE threshold S-box scheduler.
// Optional fresh-mask stalling is enabled with PRINCE_TI_FRESH_RAND_EN.
package prince_ti_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_LIN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int NIB_DEF    = 16;
  localparam int LAT_DEF    = 3;
  localparam int ROUNDS_DEF = 12;

  // Round 5 is followed by the middle M' layer; rounds 6.. use S^-1.
  localparam int MID_ROUND  = 5;
  localparam int INV_FIRST  = 6;

endpackage

// File: rtl/prince_ti_sbox_sched_if.sv
// Control bundle between the S-box scheduler (master) and the share datapath (slave).
// rnd_vld_i/rnd_req_o exist only when PRINCE_TI_FRESH_RAND_EN is defined.
interface prince_ti_sbox_sched_if #(
    parameter int LAT = 3
);
    // Handshake: start_i is a level sampled only while busy_o is low; a start
    // seen in IDLE is consumed on that edge, otherwise it is ignored.
    logic           start_i;
    logic           busy_o;
    logic           done_o;
    logic           rd_vld_o;
    logic [3:0]     rd_idx_o;
    logic [LAT-1:0] stg_en_o;
    logic           wr_en_o;
    logic [3:0]     wr_idx_o;
    logic           inv_o;
    logic           lin_en_o;
    logic           mid_o;
    logic [3:0]     round_o;
`ifdef PRINCE_TI_FRESH_RAND_EN
    logic           rnd_vld_i;
    logic           rnd_req_o;

    modport master (
        input  start_i, rnd_vld_i,
        output busy_o, done_o, rd_vld_o, rd_idx_o, stg_en_o, wr_en_o, wr_idx_o,
               inv_o, lin_en_o, mid_o, round_o, rnd_req_o
    );
    modport slave (
        output start_i, rnd_vld_i,
        input  busy_o, done_o, rd_vld_o, rd_idx_o, stg_en_o, wr_en_o, wr_idx_o,
               inv_o, lin_en_o, mid_o, round_o, rnd_req_o
    );
`else
    modport master (
        input  start_i,
        output busy_o, done_o, rd_vld_o, rd_idx_o, stg_en_o, wr_en_o, wr_idx_o,
               inv_o, lin_en_o, mid_o, round_o
    );
    modport slave (
        output start_i,
        input  busy_o, done_o, rd_vld_o, rd_idx_o, stg_en_o, wr_en_o, wr_idx_o,
               inv_o, lin_en_o, mid_o, round_o
    );
`endif
endinterface

// File: rtl/prince_ti_pipe_track.sv
// LAT-deep valid/index delay line mirroring the shared S-box pipeline.
// Stage k is enabled only when valid data enters it, so bubbles never toggle shares.
module prince_ti_pipe_track #(
    parameter int LAT = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_vld,
    input  logic [3:0]     in_idx,
    output logic [LAT-1:0] stg_en,
    output logic           out_vld,
    output logic [3:0]     out_idx,
    output logic           in_flight
);

    logic [LAT-1:0] vld_q;
    logic [3:0]     idx_q [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < LAT; k++) idx_q[k] <= 4'd0;
        end else begin
            vld_q[0] <= in_vld;
            if (in_vld) idx_q[0] <= in_idx;
            for (int k = 1; k < LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) idx_q[k] <= idx_q[k-1];
            end
        end
    end

    // in_flight ignores the last stage: a write happening now still lets DRAIN exit.
    always_comb begin
        stg_en    = '0;
        in_flight = 1'b0;
        stg_en[0] = in_vld;
        for (int k = 1; k < LAT; k++) stg_en[k] = vld_q[k-1];
        for (int k = 0; k < LAT - 1; k++) in_flight = in_flight | vld_q[k];
    end

    assign out_vld = vld_q[LAT-1];
    assign out_idx = idx_q[LAT-1];

endmodule

// File: rtl/prince_ti_sbox_sched.sv
// Nibble-serial scheduler for the 3-share PRINCE S-layer/linear-layer sequence.
// Define PRINCE_TI_FRESH_RAND_EN to stall issue on fresh-mask availability.
module prince_ti_sbox_sched
    import prince_ti_pkg::*;
#(
    parameter int NIB    = NIB_DEF,
    parameter int LAT    = LAT_DEF,
    parameter int ROUNDS = ROUNDS_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    prince_ti_sbox_sched_if.master bus,
    output state_t                 dbg_state
);

    state_t     state_q, state_d;
    logic [3:0] nib_q, nib_d;
    logic [3:0] round_q, round_d;
    logic       inv_q, mid_q;
    logic       issue_ok, rd_vld, in_flight;

`ifdef PRINCE_TI_FRESH_RAND_EN
    assign issue_ok      = bus.rnd_vld_i;
    assign bus.rnd_req_o = rd_vld;
`else
    assign issue_ok = 1'b1;
`endif

    assign rd_vld = (state_q == S_ISSUE) && issue_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        nib_d   = nib_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_ISSUE;
                    nib_d   = 4'd0;
                    round_d = 4'd0;
                end
            end
            S_ISSUE: begin
                if (rd_vld) begin
                    if (nib_q == 4'(NIB - 1)) begin
                        nib_d   = 4'd0;
                        state_d = S_DRAIN;
                    end else begin
                        nib_d = nib_q + 4'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (!in_flight)
                    state_d = (round_q == 4'(ROUNDS - 1)) ? S_DONE : S_LIN;
            end
            S_LIN: begin
                round_d = round_q + 4'd1;
                state_d = S_ISSUE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // inv/mid follow the registered round so they are flat over a whole round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_q   <= 4'd0;
            round_q <= 4'd0;
            inv_q   <= 1'b0;
            mid_q   <= 1'b0;
        end else begin
            nib_q   <= nib_d;
            round_q <= round_d;
            inv_q   <= (round_d >= 4'(INV_FIRST));
            mid_q   <= (round_d == 4'(MID_ROUND));
        end
    end

    prince_ti_pipe_track #(.LAT(LAT)) u_track (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (rd_vld),
        .in_idx    (nib_q),
        .stg_en    (bus.stg_en_o),
        .out_vld   (bus.wr_en_o),
        .out_idx   (bus.wr_idx_o),
        .in_flight (in_flight)
    );

    assign bus.busy_o   = (state_q != S_IDLE);
    assign bus.done_o   = (state_q == S_DONE);
    assign bus.lin_en_o = (state_q == S_LIN);
    assign bus.rd_vld_o = rd_vld;
    assign bus.rd_idx_o = nib_q;
    assign bus.round_o  = round_q;
    assign bus.inv_o    = inv_q;
    assign bus.mid_o    = mid_q;
    assign dbg_state    = state_q;

endmodule
